// File: rtl/hci_ecc_scrubber.sv
// hci_ecc_scrubber: background read/correct/write-back scrubber for one TCDM bank.
// Define HCI_ECC_SCRUBBER_VERIFY_EN to re-read each written-back word.
module hci_ecc_scrubber #(
    parameter int unsigned BankWords = 256,
    parameter int unsigned DW        = 32,
    parameter int unsigned IntW      = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         scrub_en_i,
    input  logic [IntW-1:0]              interval_i,
    output logic                         scrub_req_o,
    input  logic                         scrub_gnt_i,
    output logic                         scrub_wen_o,
    output logic [$clog2(BankWords)-1:0] scrub_add_o,
    output logic [DW-1:0]                scrub_wdata_o,
    input  logic                         scrub_r_valid_i,
    input  logic [DW-1:0]                ecc_corr_data_i,
    input  logic                         ecc_single_err_i,
    input  logic                         ecc_multi_err_i,
    output logic                         correctable_err_o,
    output logic                         uncorrectable_err_o,
    output logic                         pass_done_o,
    output logic                         busy_o
);

    localparam int unsigned AW = $clog2(BankWords);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RD_REQ,
        RD_RSP,
        WB_REQ,
        NEXT
`ifdef HCI_ECC_SCRUBBER_VERIFY_EN
        ,
        VF_REQ,
        VF_RSP
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [IntW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            corr_q, corr_d;
    logic            unc_q, unc_d;
    logic            last_word;
    state_e          reload_st;

    assign last_word = (ptr_q == AW'(BankWords - 1));
    // A zero interval skips WAIT entirely
    assign reload_st = (interval_i == '0) ? RD_REQ : WAIT;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        corr_d      = 1'b0;
        unc_d       = 1'b0;
        scrub_req_o = 1'b0;
        scrub_wen_o = 1'b0;
        pass_done_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (scrub_en_i) begin
                    cnt_d   = interval_i;
                    state_d = reload_st;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - IntW'(1);
                if (cnt_q <= IntW'(1)) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                scrub_req_o = 1'b1;
                scrub_wen_o = 1'b1;
                if (scrub_gnt_i) begin
                    state_d = RD_RSP;
                end
            end
            RD_RSP: begin
                if (scrub_r_valid_i) begin
                    if (ecc_multi_err_i) begin
                        unc_d   = 1'b1;
                        state_d = NEXT;
                    end else if (ecc_single_err_i) begin
                        wdata_d = ecc_corr_data_i;
                        corr_d  = 1'b1;
                        state_d = WB_REQ;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            WB_REQ: begin
                scrub_req_o = 1'b1;
                if (scrub_gnt_i) begin
`ifdef HCI_ECC_SCRUBBER_VERIFY_EN
                    state_d = VF_REQ;
`else
                    state_d = NEXT;
`endif
                end
            end
`ifdef HCI_ECC_SCRUBBER_VERIFY_EN
            VF_REQ: begin
                scrub_req_o = 1'b1;
                scrub_wen_o = 1'b1;
                if (scrub_gnt_i) begin
                    state_d = VF_RSP;
                end
            end
            VF_RSP: begin
                // Any flag after a write-back points at a stuck bit
                if (scrub_r_valid_i) begin
                    unc_d   = ecc_single_err_i | ecc_multi_err_i;
                    state_d = NEXT;
                end
            end
`endif
            NEXT: begin
                ptr_d       = last_word ? '0 : ptr_q + AW'(1);
                pass_done_o = last_word;
                if (scrub_en_i) begin
                    cnt_d   = interval_i;
                    state_d = reload_st;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            corr_q  <= 1'b0;
            unc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            corr_q  <= corr_d;
            unc_q   <= unc_d;
        end
    end

    assign scrub_add_o         = ptr_q;
    assign scrub_wdata_o       = wdata_q;
    assign correctable_err_o   = corr_q;
    assign uncorrectable_err_o = unc_q;
    assign busy_o              = (state_q != IDLE);

endmodule
